// File: rtl/bcd_count_n.sv
// ---------------------------------------------------------------------------
// bcd_count_n
//
// N-digit BCD up/down event counter for the board front panel. A free-running
// prescaler produces a count tick. The buttons edit a BCD preset (`data`),
// which can be loaded into the count and which also acts as the match target.
// A match caused by a tick sets a latch that drives a flashing LED.
//
// Build option:
//   BCD_COUNT_SATURATE_EN  - when defined, counting holds at all-9s (up) or
//                            all-0s (down) instead of wrapping around.
//
// Ports:
//   clk      in   1          single clock
//   reset    in   1          asynchronous, active-high
//   ent      in   1          count enable
//   up_down  in   1          0 = count up, 1 = count down
//   load     in   1          copy `data` into the count
//   en_bu    in   1          enables preset editing from `buttons`
//   buttons  in   DIGITS     active-low, bit i edits preset digit i
//   digits   out  4*DIGITS   current count (packed BCD, digit 0 in [3:0])
//   data     out  4*DIGITS   preset / match target (packed BCD)
//   hit      out  1          one-cycle pulse when a tick makes count == data
//   ledr     out  1          match latch AND flash phase
// ---------------------------------------------------------------------------
module bcd_count_n #(
   parameter int DIGITS    = 4,
   parameter int TICK_DIV  = 2700000,
   parameter int HOLD_CYC  = 3,
   parameter int FLASH_DIV = 9000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ent,
   input  logic                up_down,
   input  logic                load,
   input  logic                en_bu,
   input  logic [DIGITS-1:0]   buttons,
   output logic [4*DIGITS-1:0] digits,
   output logic [4*DIGITS-1:0] data,
   output logic                hit,
   output logic                ledr
);

   localparam int PRE_W   = $clog2(TICK_DIV);
   localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
   localparam int FLASH_W = $clog2(FLASH_DIV + 1);

   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

   logic [PRE_W-1:0]              pre_q, pre_d;
   logic                          tick_q, tick_d;
   logic [4*DIGITS-1:0]           digits_q, digits_d;
   logic [4*DIGITS-1:0]           data_q, data_d;
   logic [DIGITS-1:0][HOLD_W-1:0] hold_q, hold_d;
   logic                          hit_q, hit_d;
   logic                          latch_q, latch_d;
   logic                          phase_q, phase_d;
   logic [FLASH_W-1:0]            flash_q, flash_d;
   logic                          ledr_q, ledr_d;

   logic [4*DIGITS-1:0]           step_val;
   logic                          all_nine, all_zero, at_limit;

   // Per-digit next-count and preset editor.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0]        cur, step_next, dat, dat_next;
      logic [HOLD_W-1:0] hold_next;
      logic              lower_nine, lower_zero;

      assign cur = digits_q[4*gi +: 4];
      assign dat = data_q[4*gi +: 4];

      // Ripple carry/borrow: a digit moves only when every lower digit is at
      // the rollover value for the current direction.
      always_comb begin
         lower_nine = 1'b1;
         lower_zero = 1'b1;
         for (int k = 0; k < gi; k++) begin
            lower_nine = lower_nine & (digits_q[4*k +: 4] == 4'd9);
            lower_zero = lower_zero & (digits_q[4*k +: 4] == 4'd0);
         end
      end

      always_comb begin
         step_next = cur;
         if (!up_down) begin
            if (lower_nine) step_next = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
         end else begin
            if (lower_zero) step_next = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
         end
      end

      // Hold counter: one preset increment every HOLD_CYC+1 cycles of a held
      // (low) button; no carry between preset digits.
      always_comb begin
         hold_next = hold_q[gi];
         dat_next  = dat;
         if (!en_bu || buttons[gi]) begin
            hold_next = '0;
         end else if (hold_q[gi] == HOLD_LAST) begin
            hold_next = '0;
            dat_next  = (dat == 4'd9) ? 4'd0 : dat + 4'd1;
         end else begin
            hold_next = hold_q[gi] + 1'b1;
         end
      end

      assign step_val[4*gi +: 4] = step_next;
      assign data_d[4*gi +: 4]   = dat_next;
      assign hold_d[gi]          = hold_next;
   end

   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         all_nine = all_nine & (digits_q[4*k +: 4] == 4'd9);
         all_zero = all_zero & (digits_q[4*k +: 4] == 4'd0);
      end
      at_limit = up_down ? all_zero : all_nine;
   end

   always_comb begin
      pre_d    = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_d   = (pre_q == PRE_LAST);
      digits_d = digits_q;
      hit_d    = 1'b0;
      latch_d  = latch_q;

      // Load uses the pre-edit preset (data_q), even if an edit lands now.
      if (load) begin
         digits_d = data_q;
         latch_d  = 1'b0;
      end else if (ent && tick_q) begin
`ifdef BCD_COUNT_SATURATE_EN
         if (!at_limit) begin
            digits_d = step_val;
            hit_d    = (step_val == data_q);
         end
`else
         digits_d = step_val;
         hit_d    = (step_val == data_q);
`endif
      end

      if (hit_d) latch_d = 1'b1;

      // Flash phase starts high on the edge the latch sets so the LED lights
      // immediately, then toggles every FLASH_DIV cycles.
      phase_d = phase_q;
      flash_d = flash_q;
      if (!latch_d) begin
         phase_d = 1'b0;
         flash_d = '0;
      end else if (!latch_q) begin
         phase_d = 1'b1;
         flash_d = '0;
      end else if (flash_q == FLASH_LAST) begin
         phase_d = ~phase_q;
         flash_d = '0;
      end else begin
         flash_d = flash_q + 1'b1;
      end

      ledr_d = latch_d & phase_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q    <= '0;
         tick_q   <= 1'b0;
         digits_q <= '0;
         data_q   <= '0;
         hold_q   <= '0;
         hit_q    <= 1'b0;
         latch_q  <= 1'b0;
         phase_q  <= 1'b0;
         flash_q  <= '0;
         ledr_q   <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         tick_q   <= tick_d;
         digits_q <= digits_d;
         data_q   <= data_d;
         hold_q   <= hold_d;
         hit_q    <= hit_d;
         latch_q  <= latch_d;
         phase_q  <= phase_d;
         flash_q  <= flash_d;
         ledr_q   <= ledr_d;
      end
   end

   assign digits = digits_q;
   assign data   = data_q;
   assign hit    = hit_q;
   assign ledr   = ledr_q;

endmodule

// File: tb/tb_bcd_count_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_n
//
// Scoreboard bench for bcd_count_n (DIGITS=3, TICK_DIV=4, HOLD_CYC=2,
// FLASH_DIV=3). Stimulus pushes timed expectations and expected hit values;
// a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_bcd_count_n;

   localparam int D  = 3;
   localparam int TD = 4;
   localparam int HC = 2;
   localparam int FD = 3;

   localparam int S_DIGITS = 0;
   localparam int S_DATA   = 1;
   localparam int S_HIT    = 2;
   localparam int S_LEDR   = 3;

   logic          clk     = 1'b0;
   logic          reset   = 1'b1;
   logic          ent     = 1'b0;
   logic          up_down = 1'b0;
   logic          load    = 1'b0;
   logic          en_bu   = 1'b0;
   logic [D-1:0]  buttons = '1;
   logic [4*D-1:0] digits, data;
   logic          hit, ledr;

   always #5 clk = ~clk;

   bcd_count_n #(
      .DIGITS   (D),
      .TICK_DIV (TD),
      .HOLD_CYC (HC),
      .FLASH_DIV(FD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ent     (ent),
      .up_down (up_down),
      .load    (load),
      .en_bu   (en_bu),
      .buttons (buttons),
      .digits  (digits),
      .data    (data),
      .hit     (hit),
      .ledr    (ledr)
   );

   typedef struct {
      int          due;
      int          sel;
      logic [11:0] exp;
      string       name;
   } chk_t;

   chk_t        sb[$];
   logic [11:0] hit_exp[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          rel   = 0;

   always @(posedge clk) cyc++;

   task automatic compare(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end else begin
         $display("ok   %s @cyc %0d: %h", name, cyc, act);
      end
   endtask

   function automatic logic [11:0] observe(input int sel);
      case (sel)
         S_DIGITS: return digits;
         S_DATA:   return data;
         S_HIT:    return {11'd0, hit};
         default:  return {11'd0, ledr};
      endcase
   endfunction

   // Monitor: timed expectations plus every hit pulse the DUT presents.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            compare(sb[i].name, observe(sb[i].sel), sb[i].exp);
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            compare({sb[i].name, " (missed)"}, 12'hfff, sb[i].exp);
            sb.delete(i);
         end
      end
      if (hit === 1'b1) begin
         if (hit_exp.size() == 0) compare("unexpected hit", {11'd0, hit}, 12'h000);
         else                     compare("hit value", digits, hit_exp.pop_front());
      end
   end

   task automatic expect_at(input int due, input int sel, input logic [11:0] v, input string name);
      chk_t c;
      c.due = due; c.sel = sel; c.exp = v; c.name = name;
      sb.push_back(c);
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edge number (absolute) of the next count update after reset release.
   function automatic int next_upd();
      int m;
      m = cyc - rel + 1;
      while (m < TD + 1 || (m % TD) != 1) m++;
      return rel + m;
   endfunction

   task automatic tick_once(output int e);
      ent = 1'b1;
      e   = next_upd();
      edges(e - cyc);
      ent = 1'b0;
   endtask

   task automatic do_reset();
      ent = 1'b0; load = 1'b0; en_bu = 1'b0; buttons = '1; up_down = 1'b0;
      reset = 1'b1;
      edges(2);
      reset = 1'b0;
      rel   = cyc;
      expect_at(cyc, S_DIGITS, 12'h000, "reset digits");
      expect_at(cyc, S_DATA,   12'h000, "reset data");
      expect_at(cyc, S_HIT,    12'h000, "reset hit");
      expect_at(cyc, S_LEDR,   12'h000, "reset ledr");
   endtask

   task automatic edit(input logic [D-1:0] mask, input int n);
      en_bu   = 1'b1;
      buttons = ~mask;
      edges(n);
      buttons = '1;
      en_bu   = 1'b0;
   endtask

   task automatic do_load();
      load = 1'b1;
      edges(1);
      load = 1'b0;
   endtask

   initial begin
      int e, big_e;

      // ---- reset and 11 up ticks ----
      do_reset();
      ent = 1'b1;
      expect_at(rel + 4,  S_DIGITS, 12'h000, "no tick before TD+1");
      expect_at(rel + 5,  S_DIGITS, 12'h001, "first tick");
      expect_at(rel + 37, S_DIGITS, 12'h009, "9 ticks");
      expect_at(rel + 41, S_DIGITS, 12'h010, "carry 10");
      expect_at(rel + 45, S_DIGITS, 12'h011, "11 ticks");
      edges(45);
      ent = 1'b0;

      // ---- wrap / saturate at the limits ----
      edit(3'b111, 27);
      expect_at(cyc, S_DATA, 12'h999, "edit all to 999");
      do_load();
      expect_at(cyc, S_DIGITS, 12'h999, "load 999");
      edges(1);
      tick_once(e);
`ifdef BCD_COUNT_SATURATE_EN
      expect_at(cyc, S_DIGITS, 12'h999, "up at 999 saturates");
`else
      expect_at(cyc, S_DIGITS, 12'h000, "up 999 wraps");
`endif
      edges(1);
      edit(3'b111, 3);
      expect_at(cyc, S_DATA, 12'h000, "edit 999 to 000");
      do_load();
      expect_at(cyc, S_DIGITS, 12'h000, "load 000");
      up_down = 1'b1;
      tick_once(e);
`ifdef BCD_COUNT_SATURATE_EN
      expect_at(cyc, S_DIGITS, 12'h000, "down at 000 saturates");
`else
      expect_at(cyc, S_DIGITS, 12'h999, "down 000 wraps");
`endif
      up_down = 1'b0;
      edges(1);

      // ---- preset editing ----
      do_reset();
      en_bu = 1'b1; buttons = 3'b101;
      edges(3);
      expect_at(cyc, S_DATA, 12'h010, "edit first step");
      edges(6);
      expect_at(cyc, S_DATA, 12'h030, "edit 9 cycles");
      buttons = 3'b111; en_bu = 1'b0;
      edges(1);
      buttons = 3'b101;
      edges(9);
      expect_at(cyc, S_DATA, 12'h030, "edit disabled");
      buttons = 3'b111;
      edges(1);

      // ---- match, hit, flash ----
      do_reset();
      edit(3'b001, 9);
      do_load();
      expect_at(cyc, S_DIGITS, 12'h003, "load 003");
      edit(3'b001, 6);
      expect_at(cyc, S_DATA, 12'h005, "data 005");
      ent   = 1'b1;
      e     = next_upd();
      big_e = e + TD;
      hit_exp.push_back(12'h005);
      expect_at(e,          S_DIGITS, 12'h004, "count 004");
      expect_at(big_e - 1,  S_LEDR,   12'h000, "ledr before match");
      expect_at(big_e,      S_DIGITS, 12'h005, "count 005");
      expect_at(big_e,      S_LEDR,   12'h001, "ledr rises with hit");
      expect_at(big_e + 1,  S_HIT,    12'h000, "hit one cycle");
      expect_at(big_e + 2,  S_LEDR,   12'h001, "ledr high 3rd cycle");
      expect_at(big_e + 3,  S_LEDR,   12'h000, "ledr low phase");
      expect_at(big_e + 4,  S_DIGITS, 12'h006, "count past match");
      expect_at(big_e + 5,  S_LEDR,   12'h000, "ledr low 3rd cycle");
      expect_at(big_e + 6,  S_LEDR,   12'h001, "ledr high again");
      expect_at(big_e + 8,  S_DIGITS, 12'h007, "count 007");
      expect_at(big_e + 9,  S_LEDR,   12'h000, "ledr flashing");
      edges(big_e + 9 - cyc);
      ent = 1'b0;
      do_load();
      expect_at(cyc,     S_LEDR,   12'h000, "load clears ledr");
      expect_at(cyc,     S_DIGITS, 12'h005, "reload 005");
      expect_at(cyc + 4, S_LEDR,   12'h000, "ledr stays clear");
      edges(4);

      // ---- asynchronous reset while ledr is high ----
      edit(3'b001, 3);
      tick_once(e);
      #1;
      compare("hit before async reset", {11'd0, hit}, 12'h001);
      compare("ledr before async reset", {11'd0, ledr}, 12'h001);
      compare("data before async reset", data, 12'h006);
      reset = 1'b1;
      #1;
      compare("async reset digits", digits, 12'h000);
      compare("async reset data", data, 12'h000);
      compare("async reset hit", {11'd0, hit}, 12'h000);
      compare("async reset ledr", {11'd0, ledr}, 12'h000);
      edges(1);
      reset = 1'b0;
      rel   = cyc;

      // ---- load and edit on the same cycle ----
      en_bu = 1'b1; buttons = 3'b110;
      edges(27);
      expect_at(cyc, S_DATA, 12'h009, "data 009");
      edges(2);
      load = 1'b1;
      edges(1);
      load = 1'b0; buttons = '1; en_bu = 1'b0;
      expect_at(cyc, S_DIGITS, 12'h009, "load pre-edit data");
      expect_at(cyc, S_DATA,   12'h000, "edit with load");
      edges(2);

      compare("pending hits", 12'(hit_exp.size()), 12'h000);
      compare("pending checks", 12'(sb.size()), 12'h000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
